// File: rtl/mmul_parallel_engine_gen_pkg.sv
// Shared types and default constants for the parallel matrix-multiply engine.
// MMUL_ENGINE_GEN_SATURATE_EN adds a sticky saturation flag to the flags bus.
package mmul_parallel_gen_package;

  localparam int unsigned MMUL_GEN_N_CH      = 16;
  localparam int unsigned MMUL_GEN_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } engine_state_t;

  typedef struct packed {
    logic                          start;
    logic                          clear;
    logic [MMUL_GEN_CNT_WIDTH-1:0] len;
    logic [MMUL_GEN_CNT_WIDTH-1:0] n_out;
  } ctrl_engine_gen_t;

  typedef struct packed {
`ifdef MMUL_ENGINE_GEN_SATURATE_EN
    logic                          sat;
`endif
    logic                          done;
    logic                          idle;
    logic                          ready;
    logic [MMUL_GEN_CNT_WIDTH-1:0] cnt_out;
    logic [MMUL_GEN_CNT_WIDTH-1:0] cnt_beat;
  } flags_engine_gen_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream interface used for every operand lane and the result stream.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/mmul_parallel_engine_gen_dotp.sv
// Combinational N_CH-lane signed dot product folded into the running accumulator.
// MMUL_ENGINE_GEN_SATURATE_EN clamps product sum and accumulation instead of wrapping.
module mmul_parallel_dotp #(
  parameter int unsigned N_CH       = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic signed [DATA_WIDTH-1:0] i_a [N_CH],
  input  logic signed [DATA_WIDTH-1:0] i_b [N_CH],
  input  logic signed [ACC_WIDTH-1:0]  i_acc,
  input  logic                         i_first,
`ifdef MMUL_ENGINE_GEN_SATURATE_EN
  output logic                         o_sat_c,
`endif
  output logic signed [ACC_WIDTH-1:0]  o_acc_next_c
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned TREE_W = PROD_W + $clog2(N_CH) + 1;
  localparam int unsigned SUM_W  = (TREE_W > ACC_WIDTH) ? TREE_W : ACC_WIDTH + 1;

  logic signed [SUM_W-1:0]     w_sum;
  logic signed [ACC_WIDTH-1:0] w_p;

  // Full-precision sum of products; wide enough that no lane combination overflows
  always_comb begin : dotp_tree
    w_sum = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_sum = w_sum + SUM_W'(PROD_W'(i_a[i]) * PROD_W'(i_b[i]));
    end
  end

`ifdef MMUL_ENGINE_GEN_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic                 w_p_ovf;
  logic                 w_add_ovf;
  logic [ACC_WIDTH:0]   w_add;

  // Clamp whenever the bits above the accumulator sign bit are not a pure sign extension
  always_comb begin : dotp_sat
    w_p_ovf      = (w_sum[SUM_W-1:ACC_WIDTH-1] != {(SUM_W-ACC_WIDTH+1){w_sum[SUM_W-1]}});
    w_p          = w_p_ovf ? (w_sum[SUM_W-1] ? ACC_MIN : ACC_MAX) : w_sum[ACC_WIDTH-1:0];
    w_add        = {w_p[ACC_WIDTH-1], w_p} + (i_first ? '0 : {i_acc[ACC_WIDTH-1], i_acc});
    w_add_ovf    = (w_add[ACC_WIDTH] != w_add[ACC_WIDTH-1]);
    o_acc_next_c = w_add_ovf ? (w_add[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : w_add[ACC_WIDTH-1:0];
    o_sat_c      = w_p_ovf | w_add_ovf;
  end
`else
  logic w_unused_hi;

  always_comb begin : dotp_wrap
    w_p          = ACC_WIDTH'(w_sum);
    o_acc_next_c = i_first ? w_p : w_p + i_acc;
  end

  assign w_unused_hi = ^w_sum[SUM_W-1:ACC_WIDTH];
`endif

endmodule

// File: rtl/mmul_parallel_engine_gen.sv
// Joins N_CH A/B lanes, accumulates len dot products per result and emits n_out results.
// MMUL_ENGINE_GEN_SATURATE_EN selects saturating arithmetic and the sticky sat flag.
module mmul_parallel_engine_gen
  import mmul_parallel_gen_package::*;
#(
  parameter int unsigned N_CH       = MMUL_GEN_N_CH,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH  = MMUL_GEN_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_mode_i,
  hwpe_stream_intf_stream.sink   in1 [N_CH],
  hwpe_stream_intf_stream.sink   in2 [N_CH],
  hwpe_stream_intf_stream.source out_r,
  input  ctrl_engine_gen_t      ctrl_i,
  output flags_engine_gen_t     flags_o
);

  engine_state_t               r_state, w_state_n;
  logic [CNT_WIDTH-1:0]        r_len, r_n_out, r_cnt_beat, r_cnt_out;
  logic signed [ACC_WIDTH-1:0] r_acc, r_out_data, w_acc_next;
  logic                        r_out_valid, r_ready;
  logic signed [DATA_WIDTH-1:0] w_a [N_CH];
  logic signed [DATA_WIDTH-1:0] w_b [N_CH];
  logic [N_CH-1:0]             w_vld1, w_vld2, w_strb_x;
  logic w_all_valid, w_first_beat, w_last_beat, w_out_free, w_res_left;
  logic w_out_hs, w_last_hs, w_fire, w_start, w_unused;
`ifdef MMUL_ENGINE_GEN_SATURATE_EN
  logic r_sat, w_sat_evt;
`endif

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
    assign w_a[gi]       = in1[gi].data;
    assign w_b[gi]       = in2[gi].data;
    assign w_vld1[gi]    = in1[gi].valid;
    assign w_vld2[gi]    = in2[gi].valid;
    assign w_strb_x[gi]  = ^{in1[gi].strb, in2[gi].strb};
    assign in1[gi].ready = w_fire;
    assign in2[gi].ready = w_fire;
  end

  assign w_unused = test_mode_i ^ (^w_strb_x);

  mmul_parallel_dotp #(
    .N_CH       (N_CH),
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_dotp (
    .i_a          (w_a),
    .i_b          (w_b),
    .i_acc        (r_acc),
    .i_first      (w_first_beat),
`ifdef MMUL_ENGINE_GEN_SATURATE_EN
    .o_sat_c      (w_sat_evt),
`endif
    .o_acc_next_c (w_acc_next)
  );

  // Join/fire decision and next state; a result is only started while fewer than n_out are in flight
  always_comb begin : fsm_comb
    w_state_n    = r_state;
    w_start      = 1'b0;
    w_all_valid  = &{w_vld1, w_vld2};
    w_first_beat = (r_cnt_beat == '0);
    w_last_beat  = (r_cnt_beat == r_len - CNT_WIDTH'(1));
    w_out_hs     = r_out_valid & out_r.ready;
    w_out_free   = !r_out_valid | out_r.ready;
    w_res_left   = ({1'b0, r_cnt_out} + (CNT_WIDTH+1)'(r_out_valid)) < {1'b0, r_n_out};
    w_fire       = (r_state == RUN) & w_all_valid & w_res_left & (!w_last_beat | w_out_free);
    w_last_hs    = w_out_hs & (r_cnt_out == r_n_out - CNT_WIDTH'(1));
    if (ctrl_i.clear) begin
      w_state_n = IDLE;
    end else begin
      case (r_state)
        IDLE: if (ctrl_i.start) begin
          w_start   = 1'b1;
          w_state_n = (ctrl_i.len == '0 || ctrl_i.n_out == '0) ? DONE : RUN;
        end
        RUN:     if (w_last_hs) w_state_n = DONE;
        DONE:    w_state_n = IDLE;
        default: w_state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : fsm_reg
    if (!rst_ni) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ready <= (w_state_n == IDLE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : datapath
    if (!rst_ni) begin
      r_len       <= '0;
      r_n_out     <= '0;
      r_acc       <= '0;
      r_cnt_beat  <= '0;
      r_cnt_out   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
`ifdef MMUL_ENGINE_GEN_SATURATE_EN
      r_sat       <= 1'b0;
`endif
    end else if (ctrl_i.clear) begin
      r_acc       <= '0;
      r_cnt_beat  <= '0;
      r_cnt_out   <= '0;
      r_out_valid <= 1'b0;
`ifdef MMUL_ENGINE_GEN_SATURATE_EN
      r_sat       <= 1'b0;
`endif
    end else begin
      if (w_start) begin
        r_len      <= CNT_WIDTH'(ctrl_i.len);
        r_n_out    <= CNT_WIDTH'(ctrl_i.n_out);
        r_acc      <= '0;
        r_cnt_beat <= '0;
        r_cnt_out  <= '0;
`ifdef MMUL_ENGINE_GEN_SATURATE_EN
        r_sat      <= 1'b0;
`endif
      end
      if (w_out_hs) begin
        r_out_valid <= 1'b0;
        if (r_cnt_out != r_n_out) r_cnt_out <= r_cnt_out + CNT_WIDTH'(1);
      end
      // A load here overrides the drain above, giving back-to-back results
      if (w_fire) begin
        r_acc <= w_acc_next;
`ifdef MMUL_ENGINE_GEN_SATURATE_EN
        if (w_sat_evt) r_sat <= 1'b1;
`endif
        if (w_last_beat) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_acc_next;
          r_cnt_beat  <= '0;
        end else begin
          r_cnt_beat  <= r_cnt_beat + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign out_r.valid = r_out_valid;
  assign out_r.data  = r_out_data;
  assign out_r.strb  = '1;

  always_comb begin : flags_comb
    flags_o          = '0;
    flags_o.done     = (r_state == DONE);
    flags_o.idle     = (r_state == IDLE);
    flags_o.ready    = r_ready;
    flags_o.cnt_out  = MMUL_GEN_CNT_WIDTH'(r_cnt_out);
    flags_o.cnt_beat = MMUL_GEN_CNT_WIDTH'(r_cnt_beat);
`ifdef MMUL_ENGINE_GEN_SATURATE_EN
    flags_o.sat      = r_sat;
`endif
  end

endmodule

// File: tb/tb_mmul_parallel_engine_gen.sv
// Directed self-checking bench for mmul_parallel_engine_gen (16 lanes, unused lanes driven to zero).
// Expectations follow MMUL_ENGINE_GEN_SATURATE_EN when it is defined for the build.
module tb_mmul_parallel_engine_gen;
  import mmul_parallel_gen_package::*;

  localparam int unsigned NCH = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned CW  = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic test_mode;
  ctrl_engine_gen_t  ctrl;
  flags_engine_gen_t flags;
  logic              lane_valid;
  logic [DW-1:0]     a_data [NCH];
  logic [DW-1:0]     b_data [NCH];
  logic [NCH-1:0]    a_rdy, b_rdy;
  logic              out_ready;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) in1 [NCH] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) in2 [NCH] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(AW)) out_r ();

  for (genvar g = 0; g < NCH; g++) begin : g_drv
    assign in1[g].valid = lane_valid;
    assign in1[g].data  = a_data[g];
    assign in1[g].strb  = '1;
    assign in2[g].valid = lane_valid;
    assign in2[g].data  = b_data[g];
    assign in2[g].strb  = '1;
    assign a_rdy[g]     = in1[g].ready;
    assign b_rdy[g]     = in2[g].ready;
  end
  assign out_r.ready = out_ready;

  mmul_parallel_engine_gen #(
    .N_CH(NCH), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .test_mode_i (test_mode),
    .in1         (in1),
    .in2         (in2),
    .out_r       (out_r),
    .ctrl_i      (ctrl),
    .flags_o     (flags)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [DW-1:0] a, input logic [DW-1:0] b, input int n);
    for (int i = 0; i < NCH; i++) begin
      a_data[i] = (i < n) ? a : '0;
      b_data[i] = (i < n) ? b : '0;
    end
  endtask

  task automatic start_run(input int len, input int n_out);
    ctrl.start = 1'b1;
    ctrl.len   = CW'(len);
    ctrl.n_out = CW'(n_out);
    tick();
    ctrl.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; test_mode = 1'b0; ctrl = '0; lane_valid = 1'b0; out_ready = 1'b0;
    set_lanes('0, '0, 0);
    #12;
    vectors++; if (out_r.valid !== 1'b0) begin $display("FAIL rst_valid: got %b expected 0", out_r.valid); miscompares++; end
    vectors++; if (out_r.data !== 32'd0) begin $display("FAIL rst_data: got %h expected 0", out_r.data); miscompares++; end
    vectors++; if ({flags.done, flags.idle, flags.ready} !== 3'b010) begin $display("FAIL rst_flags: got done/idle/ready %b expected 010", {flags.done, flags.idle, flags.ready}); miscompares++; end
    vectors++; if ({flags.cnt_out, flags.cnt_beat} !== 32'd0) begin $display("FAIL rst_cnt: got %h expected 0", {flags.cnt_out, flags.cnt_beat}); miscompares++; end
    vectors++; if ({a_rdy, b_rdy} !== '0) begin $display("FAIL rst_lane_rdy: got %h expected 0", {a_rdy, b_rdy}); miscompares++; end
    rst_n = 1'b1;
    tick();
    vectors++; if (flags.ready !== 1'b1) begin $display("FAIL rst_ready_after: got %b expected 1", flags.ready); miscompares++; end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      a_data[i] = (i < 4) ? DW'(i + 1) : '0;
      b_data[i] = (i < 4) ? DW'(i + 5) : '0;
    end
    start_run(1, 1);
    vectors++; if ({flags.idle, flags.ready} !== 2'b00) begin $display("FAIL single_run_flags: got idle/ready %b expected 00", {flags.idle, flags.ready}); miscompares++; end
    lane_valid = 1'b1;
    #1;
    vectors++; if ({a_rdy, b_rdy} !== '1) begin $display("FAIL single_lane_rdy: got %h expected all ones", {a_rdy, b_rdy}); miscompares++; end
    tick();
    lane_valid = 1'b0;
    vectors++; if (out_r.valid !== 1'b1 || out_r.data !== 32'd70) begin $display("FAIL single_out: got valid %b data %0d expected valid 1 data 70", out_r.valid, $signed(out_r.data)); miscompares++; end
    vectors++; if (flags.done !== 1'b0) begin $display("FAIL single_done_early: got %b expected 0", flags.done); miscompares++; end
    tick();
    vectors++; if (flags.done !== 1'b1 || flags.cnt_out !== 16'd1 || out_r.valid !== 1'b0) begin $display("FAIL single_done: got done %b cnt_out %0d valid %b expected 1 1 0", flags.done, flags.cnt_out, out_r.valid); miscompares++; end
    tick();
    vectors++; if ({flags.done, flags.idle, flags.ready} !== 3'b011 || flags.cnt_out !== 16'd1) begin $display("FAIL single_idle: got done/idle/ready %b cnt_out %0d expected 011 1", {flags.done, flags.idle, flags.ready}, flags.cnt_out); miscompares++; end
  endtask

  task automatic test_back_to_back();
    logic [15:0] cnt_beat_exp [8];
    cnt_beat_exp = '{16'd0, 16'd1, 16'd2, 16'd0, 16'd1, 16'd2, 16'd0, 16'd0};
    out_ready = 1'b1;
    set_lanes(32'd1, 32'hFFFF_FFFF, 16);
    start_run(3, 2);
    for (int c = 0; c < 8; c++) begin
      vectors++; if (out_r.valid !== (c == 3 || c == 6)) begin $display("FAIL b2b_valid c%0d: got %b expected %b", c, out_r.valid, (c == 3 || c == 6)); miscompares++; end
      if (c == 3 || c == 6) begin
        vectors++; if ($signed(out_r.data) !== -32'sd48) begin $display("FAIL b2b_data c%0d: got %0d expected -48", c, $signed(out_r.data)); miscompares++; end
      end
      vectors++; if (flags.cnt_beat !== cnt_beat_exp[c]) begin $display("FAIL b2b_cnt_beat c%0d: got %0d expected %0d", c, flags.cnt_beat, cnt_beat_exp[c]); miscompares++; end
      vectors++; if (flags.done !== (c == 7)) begin $display("FAIL b2b_done c%0d: got %b expected %b", c, flags.done, (c == 7)); miscompares++; end
      lane_valid = (c < 6);
      #1;
      vectors++; if ({a_rdy, b_rdy} !== {(2*NCH){c < 6}}) begin $display("FAIL b2b_lane_rdy c%0d: got %h expected %b", c, {a_rdy, b_rdy}, (c < 6)); miscompares++; end
      tick();
    end
    lane_valid = 1'b0;
    vectors++; if (flags.cnt_out !== 16'd2 || flags.idle !== 1'b1) begin $display("FAIL b2b_end: got cnt_out %0d idle %b expected 2 1", flags.cnt_out, flags.idle); miscompares++; end
  endtask

  task automatic test_backpressure();
    logic exp_rdy;
    out_ready = 1'b1;
    set_lanes(32'd1, 32'hFFFF_FFFF, 16);
    start_run(3, 2);
    for (int c = 0; c < 11; c++) begin
      vectors++; if (out_r.valid !== (c >= 3 && c <= 9)) begin $display("FAIL bp_valid c%0d: got %b expected %b", c, out_r.valid, (c >= 3 && c <= 9)); miscompares++; end
      if (c >= 3 && c <= 9) begin
        vectors++; if ($signed(out_r.data) !== -32'sd48) begin $display("FAIL bp_data c%0d: got %0d expected -48", c, $signed(out_r.data)); miscompares++; end
      end
      if (c == 9 || c == 10) begin
        vectors++; if (flags.cnt_out !== CW'(c - 8)) begin $display("FAIL bp_cnt_out c%0d: got %0d expected %0d", c, flags.cnt_out, c - 8); miscompares++; end
      end
      vectors++; if (flags.done !== (c == 10)) begin $display("FAIL bp_done c%0d: got %b expected %b", c, flags.done, (c == 10)); miscompares++; end
      out_ready  = !(c >= 3 && c <= 7);
      lane_valid = (c < 9);
      ctrl.start = (c == 4);
      ctrl.len   = '0;
      exp_rdy    = (c <= 4) || (c == 8);
      #1;
      vectors++; if ({a_rdy, b_rdy} !== {(2*NCH){exp_rdy}}) begin $display("FAIL bp_lane_rdy c%0d: got %h expected %b", c, {a_rdy, b_rdy}, exp_rdy); miscompares++; end
      tick();
    end
    ctrl.start = 1'b0; lane_valid = 1'b0; out_ready = 1'b1;
    vectors++; if (flags.idle !== 1'b1) begin $display("FAIL bp_idle: got %b expected 1", flags.idle); miscompares++; end
  endtask

  task automatic test_zero_len();
    start_run(0, 3);
    vectors++; if (flags.done !== 1'b1 || flags.idle !== 1'b0) begin $display("FAIL zl_done: got done %b idle %b expected 1 0", flags.done, flags.idle); miscompares++; end
    vectors++; if (out_r.valid !== 1'b0 || flags.cnt_out !== 16'd0) begin $display("FAIL zl_out: got valid %b cnt_out %0d expected 0 0", out_r.valid, flags.cnt_out); miscompares++; end
    tick();
    vectors++; if (flags.idle !== 1'b1 || flags.done !== 1'b0 || out_r.valid !== 1'b0) begin $display("FAIL zl_idle: got idle %b done %b valid %b expected 1 0 0", flags.idle, flags.done, out_r.valid); miscompares++; end
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    set_lanes(32'd1, 32'd1, 4);
    start_run(3, 1);
    lane_valid = 1'b1;
    tick();
    tick();
    lane_valid = 1'b0;
    vectors++; if (flags.cnt_beat !== 16'd2) begin $display("FAIL clr_pre_beat: got %0d expected 2", flags.cnt_beat); miscompares++; end
    ctrl.clear = 1'b1;
    tick();
    ctrl.clear = 1'b0;
    vectors++; if (flags.idle !== 1'b1 || out_r.valid !== 1'b0 || flags.cnt_beat !== 16'd0) begin $display("FAIL clr_state: got idle %b valid %b cnt_beat %0d expected 1 0 0", flags.idle, out_r.valid, flags.cnt_beat); miscompares++; end
    ctrl.clear = 1'b1;
    start_run(1, 1);
    ctrl.clear = 1'b0;
    vectors++; if (flags.idle !== 1'b1 || flags.ready !== 1'b1) begin $display("FAIL clr_start_lost: got idle %b ready %b expected 1 1", flags.idle, flags.ready); miscompares++; end
    set_lanes(32'd2, 32'd2, 4);
    start_run(1, 1);
    lane_valid = 1'b1;
    tick();
    lane_valid = 1'b0;
    vectors++; if (out_r.valid !== 1'b1 || out_r.data !== 32'd16) begin $display("FAIL clr_rerun: got valid %b data %0d expected 1 16", out_r.valid, $signed(out_r.data)); miscompares++; end
    tick();
    vectors++; if (flags.done !== 1'b1) begin $display("FAIL clr_rerun_done: got %b expected 1", flags.done); miscompares++; end
    tick();
  endtask

  task automatic test_saturate();
    logic [AW-1:0] exp_data;
`ifdef MMUL_ENGINE_GEN_SATURATE_EN
    exp_data = 32'h7FFF_FFFF;
`else
    exp_data = 32'd4;
`endif
    out_ready = 1'b1;
    set_lanes(32'h7FFF_FFFF, 32'h7FFF_FFFF, 2);
    start_run(2, 1);
    lane_valid = 1'b1;
    tick();
    tick();
    lane_valid = 1'b0;
    vectors++; if (out_r.valid !== 1'b1 || out_r.data !== exp_data) begin $display("FAIL sat_data: got valid %b data %h expected 1 %h", out_r.valid, out_r.data, exp_data); miscompares++; end
`ifdef MMUL_ENGINE_GEN_SATURATE_EN
    vectors++; if (flags.sat !== 1'b1) begin $display("FAIL sat_flag: got %b expected 1", flags.sat); miscompares++; end
`endif
    tick();
    tick();
    start_run(0, 1);
`ifdef MMUL_ENGINE_GEN_SATURATE_EN
    vectors++; if (flags.sat !== 1'b0) begin $display("FAIL sat_flag_clr: got %b expected 0", flags.sat); miscompares++; end
`endif
    vectors++; if (flags.done !== 1'b1) begin $display("FAIL sat_zl_done: got %b expected 1", flags.done); miscompares++; end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    set_lanes(32'd1, 32'd1, 4);
    start_run(1, 2);
    lane_valid = 1'b1;
    tick();
    lane_valid = 1'b0;
    vectors++; if (out_r.valid !== 1'b1 || out_r.data !== 32'd4) begin $display("FAIL arst_pre: got valid %b data %0d expected 1 4", out_r.valid, $signed(out_r.data)); miscompares++; end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (out_r.valid !== 1'b0 || out_r.data !== 32'd0) begin $display("FAIL arst_out: got valid %b data %h expected 0 0", out_r.valid, out_r.data); miscompares++; end
    vectors++; if ({flags.done, flags.idle, flags.ready} !== 3'b010) begin $display("FAIL arst_flags: got done/idle/ready %b expected 010", {flags.done, flags.idle, flags.ready}); miscompares++; end
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    vectors++; if (flags.ready !== 1'b1 || flags.idle !== 1'b1) begin $display("FAIL arst_release: got ready %b idle %b expected 1 1", flags.ready, flags.idle); miscompares++; end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_zero_len();
    test_clear();
    test_saturate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
